// File: rtl/base_endian_arb_pkg.sv
// Shared definitions for the two-requester byte-swap arbiter.
package base_endian_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] FIFO_DEPTH = 2'd2;

endpackage

// File: rtl/base_endian_szl.sv
// Static byte swapper: when szl is set, output byte k takes input byte bytes-1-k.
module base_endian_szl #(
    parameter bit szl   = 1'b1,
    parameter int bytes = 8
) (
    input  logic [0:8*bytes-1] i_d,
    output logic [0:8*bytes-1] o_d
);

    generate
        for (genvar gi = 0; gi < bytes; gi++) begin : g_byte
            if (szl) begin : g_swap
                assign o_d[8*gi +: 8] = i_d[8*(bytes-1-gi) +: 8];
            end else begin : g_pass
                assign o_d[8*gi +: 8] = i_d[8*gi +: 8];
            end
        end
    endgenerate

endmodule

// File: rtl/base_endian_arb.sv
// Packet-granular round-robin arbiter feeding a shared byte-swap datapath
// into a 2-entry (main + skid) output buffer.
module base_endian_arb
    import base_endian_arb_pkg::*;
#(
    parameter int bytes = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i0_v,
    output logic               i0_r,
    input  logic [0:8*bytes-1] i0_d,
    input  logic               i0_szl,
    input  logic               i0_e,
    input  logic               i1_v,
    output logic               i1_r,
    input  logic [0:8*bytes-1] i1_d,
    input  logic               i1_szl,
    input  logic               i1_e,
    output logic               o_v,
    input  logic               o_r,
    output logic [0:8*bytes-1] o_d,
    output logic               o_e,
    output logic               o_src
);

    localparam int W = 8*bytes;

    arb_state_t     r_state;
    arb_state_t     w_state_next;
    logic           r_rr;
    logic [1:0]     r_cnt;
    logic [0:W-1]   r_main_d;
    logic [0:W-1]   r_skid_d;
    logic           r_main_e;
    logic           r_skid_e;
    logic           r_main_src;
    logic           r_skid_src;

    logic           w_gnt0;
    logic           w_gnt1;
    logic           w_full;
    logic           w_acc0;
    logic           w_acc1;
    logic           w_push;
    logic           w_pop;
    logic           w_src;
    logic           w_sel_e;
    logic           w_sel_szl;
    logic [0:W-1]   w_sel_d;
    logic [0:W-1]   w_swp_d;
    logic [0:W-1]   w_push_d;

    // Ready depends only on lock state, valids and buffer occupancy, never on o_r.
    assign w_full = (r_cnt == FIFO_DEPTH);
    assign w_acc0 = i0_v & i0_r;
    assign w_acc1 = i1_v & i1_r;
    assign w_push = w_acc0 | w_acc1;
    assign w_src  = w_acc1;
    assign w_pop  = (r_cnt != 2'd0) & o_r;

    assign w_sel_d   = w_src ? i1_d   : i0_d;
    assign w_sel_szl = w_src ? i1_szl : i0_szl;
    assign w_sel_e   = w_src ? i1_e   : i0_e;

    base_endian_szl #(
        .szl   (1'b1),
        .bytes (bytes)
    ) u_szl (
        .i_d (w_sel_d),
        .o_d (w_swp_d)
    );

    assign w_push_d = w_sel_szl ? w_swp_d : w_sel_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_push && !w_sel_e) begin
                    w_state_next = w_src ? ST_LOCK1 : ST_LOCK0;
                end
            end
            ST_LOCK0: if (w_acc0 && i0_e) w_state_next = ST_IDLE;
            ST_LOCK1: if (w_acc1 && i1_e) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i0_v && i1_v) begin
                    w_gnt0 = r_rr;
                    w_gnt1 = ~r_rr;
                end else begin
                    w_gnt0 = i0_v;
                    w_gnt1 = i1_v;
                end
            end
            ST_LOCK0: w_gnt0 = 1'b1;
            ST_LOCK1: w_gnt1 = 1'b1;
            default: begin
                w_gnt0 = 1'b0;
                w_gnt1 = 1'b0;
            end
        endcase
        i0_r = w_gnt0 & ~w_full & reset_n;
        i1_r = w_gnt1 & ~w_full & reset_n;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rr <= 1'b1;
        end else if (w_push && (r_state == ST_IDLE)) begin
            r_rr <= w_src;
        end
    end

    // Main entry drives the outputs; the skid entry only fills when main is held.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt      <= 2'd0;
            r_main_d   <= '0;
            r_main_e   <= 1'b0;
            r_main_src <= 1'b0;
            r_skid_d   <= '0;
            r_skid_e   <= 1'b0;
            r_skid_src <= 1'b0;
        end else begin
            if (w_push && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop))) begin
                r_main_d   <= w_push_d;
                r_main_e   <= w_sel_e;
                r_main_src <= w_src;
            end else if (w_push && (r_cnt == 2'd1)) begin
                r_skid_d   <= w_push_d;
                r_skid_e   <= w_sel_e;
                r_skid_src <= w_src;
            end else if (w_pop && (r_cnt == 2'd2)) begin
                r_main_d   <= r_skid_d;
                r_main_e   <= r_skid_e;
                r_main_src <= r_skid_src;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_v   = (r_cnt != 2'd0);
    assign o_d   = r_main_d;
    assign o_e   = r_main_e;
    assign o_src = r_main_src;

endmodule

// File: tb/tb_base_endian_arb.sv
// Self-checking bench for base_endian_arb: directed scenarios plus random traffic
// against a queue-based packet-arbitration model.
module tb_base_endian_arb;

    localparam int BYTES = 8;
    localparam int W     = 8*BYTES;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         i0_v, i1_v, i0_szl, i1_szl, i0_e, i1_e, o_r;
    logic [W-1:0] i0_d, i1_d;
    logic         i0_r, i1_r, o_v, o_e, o_src;
    logic [W-1:0] o_d;

    always #5 clk = ~clk;

    base_endian_arb #(.bytes(BYTES)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i0_v    (i0_v),
        .i0_r    (i0_r),
        .i0_d    (i0_d),
        .i0_szl  (i0_szl),
        .i0_e    (i0_e),
        .i1_v    (i1_v),
        .i1_r    (i1_r),
        .i1_d    (i1_d),
        .i1_szl  (i1_szl),
        .i1_e    (i1_e),
        .o_v     (o_v),
        .o_r     (o_r),
        .o_d     (o_d),
        .o_e     (o_e),
        .o_src   (o_src)
    );

    typedef struct {
        logic [W-1:0] d;
        bit           e;
        bit           src;
    } beat_t;

    int    n_total = 0;
    int    n_bad   = 0;
    beat_t exp_q[$];
    int    owner   = -1;
    int    rr      = 1;
    logic  cap_r0, cap_r1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Byte reversal by peeling bytes off the low end and shifting them in.
    function automatic logic [W-1:0] model_data(input logic [W-1:0] d, input bit s);
        logic [W-1:0] res;
        if (!s) return d;
        res = '0;
        for (int k = 0; k < BYTES; k++) begin
            res = (res << 8) | ((d >> (8*k)) & {{(W-8){1'b0}}, 8'hff});
        end
        return res;
    endfunction

    task automatic tick(input string tag);
        int    pick;
        bit    er0, er1, acc, pop, do_rst;
        beat_t b;
        #1;
        do_rst = !reset_n;
        if (owner >= 0)          pick = owner;
        else if (i0_v && i1_v)   pick = 1 - rr;
        else if (i0_v)           pick = 0;
        else if (i1_v)           pick = 1;
        else                     pick = -1;
        er0 = !do_rst && (pick == 0) && (exp_q.size() < 2);
        er1 = !do_rst && (pick == 1) && (exp_q.size() < 2);
        cap_r0 = i0_r;
        cap_r1 = i1_r;
        check({tag, "_r0"}, {63'd0, i0_r}, {63'd0, er0});
        check({tag, "_r1"}, {63'd0, i1_r}, {63'd0, er1});
        acc = (er0 && i0_v) || (er1 && i1_v);
        b.src = (pick == 1);
        b.d   = model_data(b.src ? i1_d : i0_d, b.src ? i1_szl : i0_szl);
        b.e   = b.src ? i1_e : i0_e;
        pop   = (exp_q.size() > 0) && o_r;
        @(posedge clk);
        #1;
        if (do_rst) begin
            exp_q.delete();
            owner = -1;
            rr    = 1;
            check({tag, "_rst_ov"},  {63'd0, o_v},   64'd0);
            check({tag, "_rst_od"},  o_d,            64'd0);
            check({tag, "_rst_oe"},  {63'd0, o_e},   64'd0);
            check({tag, "_rst_src"}, {63'd0, o_src}, 64'd0);
        end else begin
            if (pop) begin
                $display("beat out: src=%0d e=%0d d=%h", exp_q[0].src, exp_q[0].e, exp_q[0].d);
                void'(exp_q.pop_front());
            end
            if (acc) begin
                if (owner < 0) begin
                    rr = pick;
                    if (!b.e) owner = pick;
                end else if (b.e) begin
                    owner = -1;
                end
                exp_q.push_back(b);
            end
            check({tag, "_ov"}, {63'd0, o_v}, {63'd0, exp_q.size() > 0});
            if (exp_q.size() > 0) begin
                check({tag, "_od"},  o_d,            exp_q[0].d);
                check({tag, "_oe"},  {63'd0, o_e},   {63'd0, exp_q[0].e});
                check({tag, "_src"}, {63'd0, o_src}, {63'd0, exp_q[0].src});
            end
        end
    endtask

    task automatic idle_inputs();
        i0_v = 0; i1_v = 0; i0_szl = 0; i1_szl = 0; i0_e = 0; i1_e = 0;
        i0_d = '0; i1_d = '0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        idle_inputs();
        o_r = 1;
        tick("rst");
        reset_n = 1;
    endtask

    initial begin
        int acc_cnt;
        reset_n = 0;
        o_r     = 1;
        idle_inputs();
        do_reset();
        do_reset();

        // Byte swap on and off
        i0_v = 1; i0_d = 64'h0011223344556677; i0_szl = 1; i0_e = 1;
        tick("swap1");
        check("swap1_const_od",  o_d, 64'h7766554433221100);
        check("swap1_const_src", {63'd0, o_src}, 64'd0);
        check("swap1_const_oe",  {63'd0, o_e}, 64'd1);
        i0_szl = 0;
        tick("swap0");
        check("swap0_const_od", o_d, 64'h0011223344556677);
        check("swap0_const_ov", {63'd0, o_v}, 64'd1);

        // Round-robin on ties
        do_reset();
        for (int i = 0; i < 4; i++) begin
            i0_v = 1; i1_v = 1; i0_e = 1; i1_e = 1;
            i0_d = {$urandom, $urandom}; i1_d = {$urandom, $urandom};
            tick("tie");
            check($sformatf("tie_src%0d", i), {63'd0, o_src}, (i % 2 == 0) ? 64'd0 : 64'd1);
        end

        // Packet lock
        do_reset();
        for (int i = 0; i < 3; i++) begin
            i0_v = 1; i1_v = 1; i0_e = (i == 2); i1_e = 1;
            i0_d = {$urandom, $urandom}; i1_d = {$urandom, $urandom};
            tick("lock");
            check($sformatf("lock_r1_%0d", i), {63'd0, cap_r1}, 64'd0);
            check($sformatf("lock_src_%0d", i), {63'd0, o_src}, 64'd0);
        end
        tick("lock_i1");
        check("lock_i1_r1",  {63'd0, cap_r1}, 64'd1);
        check("lock_i1_src", {63'd0, o_src}, 64'd1);

        // Backpressure
        do_reset();
        idle_inputs();
        o_r = 0;
        acc_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            i0_v = 1; i0_e = 0; i0_szl = $urandom_range(1); i0_d = {$urandom, $urandom};
            tick("bp");
            if (cap_r0) acc_cnt++;
        end
        check("bp_accepted", acc_cnt, 64'd2);
        check("bp_r0_stall", {63'd0, cap_r0}, 64'd0);
        i0_v = 0; o_r = 1;
        for (int i = 0; i < 3; i++) tick("bp_drain");
        check("bp_drained", {63'd0, o_v}, 64'd0);

        // Reset mid-packet with beats buffered
        do_reset();
        idle_inputs();
        o_r = 0;
        for (int i = 0; i < 2; i++) begin
            i0_v = 1; i0_e = 0; i0_d = {$urandom, $urandom};
            tick("mid");
        end
        reset_n = 0;
        tick("mid_rst");
        reset_n = 1;
        idle_inputs();
        o_r = 1;
        i1_v = 1; i1_e = 1; i1_d = {$urandom, $urandom};
        tick("mid_i1");
        check("mid_i1_r1",  {63'd0, cap_r1}, 64'd1);
        check("mid_i1_ov",  {63'd0, o_v},   64'd1);
        check("mid_i1_src", {63'd0, o_src}, 64'd1);

        // Random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset_n = ($urandom_range(99) != 0);
            i0_v = ($urandom_range(9) < 7); i1_v = ($urandom_range(9) < 7);
            i0_e = ($urandom_range(9) < 3); i1_e = ($urandom_range(9) < 3);
            i0_szl = $urandom_range(1); i1_szl = $urandom_range(1);
            i0_d = {$urandom, $urandom}; i1_d = {$urandom, $urandom};
            o_r = ($urandom_range(9) < 7);
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/base_endian_arb.md
BASE_ENDIAN_ARB -- requirements
Module: base_endian_arb

Interface
REQ-001 SHALL have parameter bytes, default 8: data width in bytes; byte 0 occupies bits [0:7] (big-endian numbering).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports i0_v / i1_v  input  1  requester 0/1 beat valid.
REQ-005 SHALL have ports i0_r / i1_r  output  1  requester 0/1 beat accepted when v&r.
REQ-006 SHALL have ports i0_d / i1_d  input  [0:8*bytes-1]  requester beat data.
REQ-007 SHALL have ports i0_szl / i1_szl  input  1  per-beat control: 1 = byte-reverse the beat, 0 = pass through.
REQ-008 SHALL have ports i0_e / i1_e  input  1  last beat of packet.
REQ-009 SHALL have port o_v  output  1  output beat valid.
REQ-010 SHALL have port o_r  input  1  downstream ready.
REQ-011 SHALL have port o_d  output  [0:8*bytes-1]  processed data.
REQ-012 SHALL have port o_e  output  1  last beat, copied from the accepted input beat.
REQ-013 SHALL have port o_src  output  1  index of the requester that supplied the beat.

Function
REQ-014 SHALL share one byte-swap datapath between two requesters at packet granularity: once a packet's first beat is accepted, only that requester is served until its e=1 beat is accepted.
REQ-015 SHALL use arbiter states IDLE, LOCK0, LOCK1.
REQ-016 SHALL, in IDLE with exactly one requester valid, grant that requester.
REQ-017 SHALL, in IDLE with both requesters valid, grant the requester not named by last-grant pointer rr.
REQ-018 SHALL update rr to the granted index on every accepted first beat.
REQ-019 SHALL transition IDLE->LOCKn on an accepted first beat with e=0, and stay in IDLE when that beat has e=1 (single-beat packet).
REQ-020 SHALL transition LOCKn->IDLE on an accepted beat from requester n with e=1.
REQ-021 SHALL hold the state when no beat is accepted.
REQ-022 SHALL drive in_r = grant & ~buffer_full; an ungranted requester's r SHALL be 0 (in LOCKn, the other r is always 0).
REQ-023 SHALL NOT let i*_r depend combinationally on o_r.
REQ-024 SHALL byte-swap: when szl=1, output byte k = input byte bytes-1-k for k=0..bytes-1; when szl=0, o_d = input data unchanged.
REQ-025 SHALL apply the swap before buffering.
REQ-026 SHALL buffer output in a 2-entry FIFO (main + skid).
REQ-027 SHALL present an accepted beat on o_d/o_e/o_src with o_v=1 exactly 1 cycle after acceptance when the FIFO was empty.
REQ-028 SHALL sustain 1 beat/cycle while o_r=1.
REQ-029 SHALL preserve beat order.
REQ-030 SHALL hold o_d/o_e/o_src stable while o_v=1 & o_r=0.
REQ-031 SHALL have buffer_full true when both entries are occupied; simultaneous push and pop when full SHALL NOT occur, because r=0.
REQ-032 SHALL, when the FIFO is at 1 entry and push and pop happen in the same cycle, keep occupancy at 1 with the new beat next.
REQ-033 SHALL ignore i*_d/szl/e when v&r=0.
REQ-034 SHALL not care about o_d contents when o_v=0.

Reset
REQ-035 SHALL, while reset_n=0 at a clk edge, set: state=IDLE, rr=1 (requester 0 wins first tie), FIFO empty, o_v=0, o_e=0, o_src=0, o_d=0.
REQ-036 SHALL hold i0_r=i1_r=0 throughout reset.
REQ-037 SHALL, on reset asserted mid-packet or with beats buffered, discard the buffered beats and leave the lock state with no partial-packet recovery.
REQ-038 SHALL accept beats from the first cycle after reset_n=1.

Structure
REQ-039 SHALL place state encoding (IDLE/LOCK0/LOCK1) in a shared package.
REQ-040 SHALL keep the module self-contained except for one sub-module: the codebase static swapper base_endian_szl instantiated with szl=1, bytes=bytes; its output SHALL be muxed against unswapped data by the per-beat szl.
REQ-041 SHALL be implementable in 120-400 lines of RTL.

Verification
REQ-042 SHALL verify byte swap: bytes=8, i0 beat d=0x0011223344556677 szl=1 e=1, o_r=1 -> next cycle o_v=1, o_d=0x7766554433221100, o_src=0, o_e=1; the same beat with szl=0 -> o_d=0x0011223344556677.
REQ-043 SHALL verify tie/round-robin: after reset both valid with 1-beat packets continuously, o_r=1 -> o_src sequence 0,1,0,1 at one beat per cycle.
REQ-044 SHALL verify packet lock: i0 sends 3-beat packet (e on beat 3) while i1 valid throughout -> i1_r=0 until i0 beat 3 accepted; outputs i0,i0,i0 then i1.
REQ-045 SHALL verify backpressure: o_r=0 with i0 streaming -> exactly 2 beats accepted, then i0_r=0; o_r=1 -> beats drain in order with no loss or duplication.
REQ-046 SHALL verify reset mid-packet: i0 beat 2 of 4 accepted and 2 beats buffered, reset_n=0 one cycle -> o_v=0, state IDLE; then i1 single beat -> granted, o_src=1.
